// File: rtl/mandel_pixel_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : mandel_pixel_dispatch
// Brief    : Walks a frame in row-major order. Feeds each pixel's c value to an
//            external iterator and hands its iteration count out on a
//            valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module mandel_pixel_dispatch #(
  parameter int COORD_W = 27,
  parameter int CNT_W   = 16,
  parameter int X_W     = 10,
  parameter int Y_W     = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  input  logic signed [COORD_W-1:0] x_start,
  input  logic signed [COORD_W-1:0] y_start,
  input  logic signed [COORD_W-1:0] dx,
  input  logic signed [COORD_W-1:0] dy,
  input  logic        [X_W-1:0]     width,
  input  logic        [Y_W-1:0]     height,
  input  logic        [CNT_W-1:0]   max_iterations,
  output logic signed [COORD_W-1:0] iter_cr,
  output logic signed [COORD_W-1:0] iter_ci,
  output logic                      iter_reset,
  output logic        [CNT_W-1:0]   iter_max,
  input  logic        [CNT_W-1:0]   iter_count,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic        [X_W-1:0]     pix_x,
  output logic        [Y_W-1:0]     pix_y,
  output logic        [CNT_W-1:0]   pix_iter
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_LOAD = 2'd1;
  localparam logic [1:0] c_RUN  = 2'd2;
  localparam logic [1:0] c_EMIT = 2'd3;

  localparam logic [X_W-1:0] c_X_ONE = X_W'(1);
  localparam logic [Y_W-1:0] c_Y_ONE = Y_W'(1);

  logic [1:0]                r_state;
  logic signed [COORD_W-1:0] r_x_start;
  logic signed [COORD_W-1:0] r_dx;
  logic signed [COORD_W-1:0] r_dy;
  logic [X_W-1:0]            r_width;
  logic [Y_W-1:0]            r_height;
  logic [X_W-1:0]            r_x;
  logic [Y_W-1:0]            r_y;
  logic signed [COORD_W-1:0] r_cr;
  logic signed [COORD_W-1:0] r_ci;
  logic [CNT_W-1:0]          r_iter_max;
  logic [CNT_W-1:0]          r_prev_count;
  logic [CNT_W-1:0]          r_pix_iter;
  logic                      r_done;
  logic                      r_iter_reset;

  logic w_x_last;
  logic w_y_last;
  logic w_pixel_finished;

  assign w_x_last = (r_x == r_width - c_X_ONE);
  assign w_y_last = (r_y == r_height - c_Y_ONE);

  // A stalled nonzero count means the iterator has escaped and stopped stepping.
  assign w_pixel_finished = (iter_count == r_iter_max) ||
                            ((iter_count != '0) && (iter_count == r_prev_count));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= c_IDLE;
      r_x_start    <= '0;
      r_dx         <= '0;
      r_dy         <= '0;
      r_width      <= '0;
      r_height     <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_cr         <= '0;
      r_ci         <= '0;
      r_iter_max   <= '0;
      r_prev_count <= '0;
      r_pix_iter   <= '0;
      r_done       <= 1'b0;
      r_iter_reset <= 1'b1;
    end else begin
      r_done       <= 1'b0;
      r_iter_reset <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            if ((width != '0) && (height != '0)) begin
              r_x_start    <= x_start;
              r_dx         <= dx;
              r_dy         <= dy;
              r_width      <= width;
              r_height     <= height;
              r_iter_max   <= max_iterations;
              r_x          <= '0;
              r_y          <= '0;
              r_cr         <= x_start;
              r_ci         <= y_start;
              r_iter_reset <= 1'b1;
              r_state      <= c_LOAD;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        c_LOAD: begin
          r_prev_count <= '0;
          r_state      <= c_RUN;
        end
        c_RUN: begin
          r_prev_count <= iter_count;
          if (w_pixel_finished) begin
            r_pix_iter <= iter_count;
            r_state    <= c_EMIT;
          end
        end
        c_EMIT: begin
          if (pix_ready) begin
            if (!w_x_last) begin
              r_x          <= r_x + c_X_ONE;
              r_cr         <= r_cr + r_dx;
              r_iter_reset <= 1'b1;
              r_state      <= c_LOAD;
            end else if (!w_y_last) begin
              r_x          <= '0;
              r_cr         <= r_x_start;
              r_y          <= r_y + c_Y_ONE;
              r_ci         <= r_ci + r_dy;
              r_iter_reset <= 1'b1;
              r_state      <= c_LOAD;
            end else begin
              r_done  <= 1'b1;
              r_state <= c_IDLE;
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign busy       = (r_state != c_IDLE);
  assign pix_valid  = (r_state == c_EMIT);
  assign done       = r_done;
  assign iter_cr    = r_cr;
  assign iter_ci    = r_ci;
  assign iter_reset = r_iter_reset;
  assign iter_max   = r_iter_max;
  assign pix_x      = r_x;
  assign pix_y      = r_y;
  assign pix_iter   = r_pix_iter;

endmodule
`default_nettype wire

// File: tb/tb_mandel_pixel_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_mandel_pixel_dispatch
// Brief    : Self-checking bench with a reference Mandelbrot iterator attached.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mandel_pixel_dispatch;

  localparam longint c_ONE  = 64'sd8388608;     // 1.0 in 4.23
  localparam longint c_HALF = 64'sd4194304;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               busy, done;
  logic signed [26:0] x_start, y_start, dx, dy;
  logic [9:0]         width, height;
  logic [15:0]        max_iterations;
  logic signed [26:0] iter_cr, iter_ci;
  logic               iter_reset;
  logic [15:0]        iter_max, iter_count;
  logic               pix_valid, pix_ready;
  logic [9:0]         pix_x, pix_y;
  logic [15:0]        pix_iter;

  always #5 clk = ~clk;

  mandel_pixel_dispatch dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .x_start(x_start), .y_start(y_start), .dx(dx), .dy(dy),
    .width(width), .height(height), .max_iterations(max_iterations),
    .iter_cr(iter_cr), .iter_ci(iter_ci), .iter_reset(iter_reset),
    .iter_max(iter_max), .iter_count(iter_count),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_iter(pix_iter)
  );

  typedef struct {
    int x, y, iter, mx;
    longint cr, ci;
  } exp_t;

  typedef struct {
    longint xs, ys, dx, dy;
    int w, h, mx;
    int first_iter;   // hand-derived count for pixel (0,0)
    bit rand_ready;
  } cfg_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   valid_cnt = 0;
  bit   rand_ready = 1'b0;
  bit   ready_fixed = 1'b1;

  function automatic bit escaped(longint zr, longint zi);
    return (zr * zr + zi * zi) >= (longint'(4) <<< 46);
  endfunction

  function automatic int mref(longint cr, longint ci, int mx);
    longint zr = 0, zi = 0, t;
    int n = 0;
    while (n < mx && !escaped(zr, zi)) begin
      t  = ((zr * zr - zi * zi) >>> 23) + cr;
      zi = ((2 * zr * zi) >>> 23) + ci;
      zr = t;
      n++;
    end
    return n;
  endfunction

  // Reference iterator: steps once per cycle until escape or the cap.
  longint      it_zr, it_zi;
  logic [15:0] it_cnt;
  assign iter_count = it_cnt;
  always @(posedge clk) begin
    if (iter_reset) begin
      it_zr <= 0; it_zi <= 0; it_cnt <= '0;
    end else if (it_cnt < iter_max && !escaped(it_zr, it_zi)) begin
      it_zr  <= ((it_zr * it_zr - it_zi * it_zi) >>> 23) + longint'(iter_cr);
      it_zi  <= ((2 * it_zr * it_zi) >>> 23) + longint'(iter_ci);
      it_cnt <= it_cnt + 16'd1;
    end
  end

  initial begin
    pix_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      pix_ready = rand_ready ? 1'($urandom_range(1, 0)) : ready_fixed;
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) done_cnt++;
    if (pix_valid) valid_cnt++;
    if (!reset && pix_valid && pix_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_pixel: got pixel (%0d,%0d), required none", pix_x, pix_y);
      end else begin
        e = exp_q.pop_front();
        check("pix_x",    longint'(pix_x),    longint'(e.x));
        check("pix_y",    longint'(pix_y),    longint'(e.y));
        check("pix_iter", longint'(pix_iter), longint'(e.iter));
        check("iter_cr",  longint'(iter_cr),  e.cr);
        check("iter_ci",  longint'(iter_ci),  e.ci);
        check("iter_max", longint'(iter_max), longint'(e.mx));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic launch(input cfg_t c, input bit scramble);
    logic signed [26:0] wcr, wci;
    exp_t e;
    x_start = 27'(c.xs); y_start = 27'(c.ys); dx = 27'(c.dx); dy = 27'(c.dy);
    width = 10'(c.w); height = 10'(c.h); max_iterations = 16'(c.mx);
    rand_ready = c.rand_ready;
    for (int y = 0; y < c.h; y++)
      for (int x = 0; x < c.w; x++) begin
        wcr = 27'(c.xs + longint'(x) * c.dx);
        wci = 27'(c.ys + longint'(y) * c.dy);
        e.x = x; e.y = y; e.mx = c.mx;
        e.cr = longint'(wcr); e.ci = longint'(wci);
        e.iter = (x == 0 && y == 0) ? c.first_iter
                                    : mref(longint'(wcr), longint'(wci), c.mx);
        exp_q.push_back(e);
      end
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (scramble) begin
      // Config and a second start mid-frame must not disturb the frame.
      tick();
      x_start = 27'(3 * c_ONE); y_start = 27'(-3 * c_ONE); dx = 27'(c_HALF);
      dy = 27'(c_HALF); width = 10'd5; height = 10'd5; max_iterations = 16'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
    end
  endtask

  task automatic finish_frame(input string name);
    for (int i = 0; i < 20000 && done_cnt == 0; i++) tick();
    check({name, "_done_seen"}, longint'(done_cnt > 0), 1);
    tick(); tick();
    check({name, "_done_once"}, done_cnt, 1);
    check({name, "_busy_low"},  longint'(busy), 0);
    check({name, "_all_pixels"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  cfg_t tbl[6];
  cfg_t hc;
  int   vsave, k;

  initial begin
    tbl[0] = '{-2*c_ONE, c_ONE, c_ONE, -c_ONE, 2, 2, 16, 1, 1'b0};
    tbl[1] = '{2*c_ONE, 0, 0, 0, 1, 1, 100, 1, 1'b0};
    tbl[2] = '{-3*c_HALF, c_HALF, c_HALF, -c_HALF, 3, 2, 20, 3, 1'b1};
    tbl[3] = '{-c_HALF, -c_ONE, 0, 3*c_ONE/4, 1, 3, 12, 4, 1'b1};
    tbl[4] = '{15*c_HALF, 15*c_HALF, c_ONE, c_ONE, 2, 2, 10, 1, 1'b0};
    tbl[5] = '{-3*c_ONE/4, 0, 3*c_ONE/4, 0, 4, 1, 30, 30, 1'b1};

    reset = 1'b1; start = 1'b0;
    x_start = '0; y_start = '0; dx = '0; dy = '0;
    width = '0; height = '0; max_iterations = '0;
    tick(); tick();
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_valid", longint'(pix_valid), 0);
    check("rst_iter_reset", longint'(iter_reset), 1);
    check("rst_zeros", longint'({pix_x, pix_y, pix_iter, iter_cr, iter_ci, iter_max}), 0);
    reset = 1'b0;
    tick();
    check("idle_iter_reset", longint'(iter_reset), 0);

    for (int i = 0; i < 6; i++) begin
      launch(tbl[i], 1'b1);
      finish_frame($sformatf("frame%0d", i));
    end

    // c=0, cap 5: EMIT one cycle after the count reads 5, then hold with ready low.
    hc = '{0, 0, 0, 0, 1, 1, 5, 5, 1'b0};
    ready_fixed = 1'b0;
    launch(hc, 1'b0);
    k = 0;
    for (int i = 0; i < 100 && k < 2; i++) begin
      if (iter_reset) k = 1;
      else if (k == 1 && iter_count == 16'd5) k = 2;
      if (k < 2) tick();
    end
    check("cap_count_seen", k, 2);
    check("cap_not_yet_valid", longint'(pix_valid), 0);
    tick();
    check("cap_emit_next", longint'(pix_valid), 1);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("hold_valid", longint'(pix_valid), 1);
      check("hold_xy", longint'({pix_x, pix_y}), 0);
      check("hold_iter", longint'(pix_iter), 5);
    end
    ready_fixed = 1'b1;
    finish_frame("hold");

    // Empty frames: done next cycle, nothing emitted.
    for (int i = 0; i < 2; i++) begin
      vsave = valid_cnt;
      width = (i == 0) ? 10'd0 : 10'd3;
      height = (i == 0) ? 10'd2 : 10'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("empty_done", longint'(done), 1);
      check("empty_busy", longint'(busy), 0);
      tick();
      check("empty_done_pulse", longint'(done), 0);
      check("empty_no_valid", valid_cnt - vsave, 0);
    end

    // Reset while pixel (1,0) is running, then a fresh frame.
    hc = '{2*c_ONE, 0, -3*c_ONE, 0, 2, 1, 100, 1, 1'b0};
    launch(hc, 1'b0);
    k = 0;
    for (int i = 0; i < 300 && k == 0; i++) begin
      if (busy && !pix_valid && !iter_reset && pix_x == 10'd1) k = 1;
      else tick();
    end
    check("mid_run_reached", k, 1);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    check("mid_rst_busy", longint'(busy), 0);
    check("mid_rst_done", longint'(done), 0);
    check("mid_rst_valid", longint'(pix_valid), 0);
    check("mid_rst_iter_reset", longint'(iter_reset), 1);
    check("mid_rst_zeros", longint'({pix_x, pix_y, pix_iter, iter_cr, iter_ci, iter_max}), 0);
    exp_q.delete();
    reset = 1'b0;
    tick();
    check("mid_idle_iter_reset", longint'(iter_reset), 0);
    launch(tbl[0], 1'b0);
    finish_frame("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got no end of test, required end of test");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
